// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan path: segment patterns for
// digits, dash and blank, plus the BCD code that selects a dark digit.
package seg_pkg;

  localparam int SEG_W = 7;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  // Bit order is {a,b,c,d,e,f,g}, active-high.
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

  localparam logic [SEG_W-1:0] SEG_DIGIT [0:9] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };

endpackage

// File: rtl/bcd_seg_decode.sv
// Combinational BCD-to-segment decoder. Codes A..E show a dash, F is dark.
module bcd_seg_decode
  import seg_pkg::*;
(
  input  logic [3:0]       code,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (code)
      4'd0:      seg = SEG_DIGIT[0];
      4'd1:      seg = SEG_DIGIT[1];
      4'd2:      seg = SEG_DIGIT[2];
      4'd3:      seg = SEG_DIGIT[3];
      4'd4:      seg = SEG_DIGIT[4];
      4'd5:      seg = SEG_DIGIT[5];
      4'd6:      seg = SEG_DIGIT[6];
      4'd7:      seg = SEG_DIGIT[7];
      4'd8:      seg = SEG_DIGIT[8];
      4'd9:      seg = SEG_DIGIT[9];
      BCD_BLANK: seg = SEG_BLANK;
      default:   seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with a shadow/active buffer
// pair that only swaps at frame end, plus optional leading-zero blanking.
module digit_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NDIG = 4,
  parameter int DIV  = 1000,
  parameter int GAP  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [4*NDIG-1:0] din,
  input  logic              lzb,
  output logic [NDIG-1:0]   an,
  output logic [SEG_W-1:0]  seg,
  output logic              pend,
  output logic              frame
);

  localparam int CW = (DIV  > 1) ? $clog2(DIV)  : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [NDIG-1:0][3:0]  shadow;
  logic [NDIG-1:0][3:0]  active;

  logic                  slot_end;
  logic                  fe;
  logic                  in_gap;
  logic [NDIG-1:0]       lead_zero;
  logic                  run_zero;
  logic [3:0]            eff_code;
  logic [SEG_W-1:0]      dec_seg;

  assign slot_end = (cnt == CW'(DIV - 1));
  assign fe       = slot_end && (idx == IW'(NDIG - 1));
  assign in_gap   = int'(cnt) < GAP;

  // lead_zero[k]: every active digit from the top down to k is zero.
  always_comb begin
    lead_zero = '0;
    run_zero  = 1'b1;
    for (int k = NDIG - 1; k >= 0; k--) begin
      run_zero     = run_zero && (active[k] == 4'd0);
      lead_zero[k] = run_zero;
    end
  end

  always_comb begin
    eff_code = active[idx];
    if (lzb && (idx != '0) && lead_zero[idx])
      eff_code = BCD_BLANK;
  end

  bcd_seg_decode u_dec (
    .code (eff_code),
    .seg  (dec_seg)
  );

  // load is a single-cycle strobe with no back-pressure: every cycle it is
  // high, din is taken, and the newest value always overrides older shadow data.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      idx    <= '0;
      shadow <= {NDIG{BCD_BLANK}};
      active <= {NDIG{BCD_BLANK}};
      pend   <= 1'b0;
      an     <= '0;
      seg    <= '0;
      frame  <= 1'b0;
    end else begin
      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == IW'(NDIG - 1)) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (fe) begin
        // A load landing on the frame edge bypasses the shadow stage.
        active <= load ? din : shadow;
        if (load)
          shadow <= din;
        pend  <= 1'b0;
        frame <= 1'b1;
      end else begin
        frame <= 1'b0;
        if (load) begin
          shadow <= din;
          pend   <= 1'b1;
        end
      end

      an  <= in_gap ? '0 : (NDIG'(1) << idx);
      seg <= in_gap ? '0 : dec_seg;
    end
  end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Scoreboard bench for digit_scan_ctrl: a time-based reference model predicts
// every registered output, a monitor compares each cycle on the falling edge.
module tb_digit_scan_ctrl;

  localparam int NDIG  = 4;
  localparam int DIV   = 4;
  localparam int GAP   = 1;
  localparam int FLEN  = NDIG * DIV;
  localparam int W     = NDIG + 7 + 2;

  logic              clk;
  logic              rst;
  logic              load;
  logic [4*NDIG-1:0] din;
  logic              lzb;
  logic [NDIG-1:0]   an;
  logic [6:0]        seg;
  logic              pend;
  logic              frame;

  digit_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .GAP(GAP)) dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .din   (din),
    .lzb   (lzb),
    .an    (an),
    .seg   (seg),
    .pend  (pend),
    .frame (frame)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  int   m_t;
  int   m_active [NDIG];
  int   m_shadow [NDIG];
  bit   m_pend;
  logic [W-1:0] exp_q [$];

  int vectors;
  int miscompares;

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'b1111110;  1: return 7'b0110000;
      2: return 7'b1101101;  3: return 7'b1111001;
      4: return 7'b0110011;  5: return 7'b1011011;
      6: return 7'b1011111;  7: return 7'b1110000;
      8: return 7'b1111111;  9: return 7'b1111011;
      15: return 7'b0000000;
      default: return 7'b0000001;
    endcase
  endfunction

  function automatic logic [W-1:0] predict(input bit l, input bit z);
    int pos, dig, top;
    bit fe;
    logic [NDIG-1:0] e_an;
    logic [6:0] e_seg;
    bit e_pend;
    pos = m_t % DIV;
    dig = (m_t / DIV) % NDIG;
    fe  = (m_t % FLEN) == FLEN - 1;
    top = -1;
    for (int k = 0; k < NDIG; k++)
      if (m_active[k] != 0) top = k;
    if (pos < GAP) begin
      e_an  = '0;
      e_seg = '0;
    end else begin
      e_an  = '0;
      e_an[dig] = 1'b1;
      if (z && dig > 0 && dig > top) e_seg = 7'b0000000;
      else e_seg = seg_of(m_active[dig]);
    end
    e_pend = fe ? 1'b0 : (l ? 1'b1 : m_pend);
    return {e_an, e_seg, e_pend, fe};
  endfunction

  // ---------------- driver ----------------
  task automatic do_cycle(input bit r, input bit l, input logic [4*NDIG-1:0] d, input bit z);
    logic [W-1:0] e;
    bit fe;
    @(negedge clk);
    rst = r; load = l; din = d; lzb = z;
    if (r) begin
      e = '0;
      m_t = 0;
      m_pend = 0;
      for (int k = 0; k < NDIG; k++) begin
        m_active[k] = 15;
        m_shadow[k] = 15;
      end
    end else begin
      e  = predict(l, z);
      fe = (m_t % FLEN) == FLEN - 1;
      if (l)
        for (int k = 0; k < NDIG; k++) m_shadow[k] = int'(d[4*k +: 4]);
      if (fe) begin
        for (int k = 0; k < NDIG; k++) m_active[k] = m_shadow[k];
        m_pend = 0;
      end else if (l) begin
        m_pend = 1;
      end
      m_t++;
    end
    @(posedge clk);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input bit z);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, '0, z);
  endtask

  // Idle until the next cycle is a frame end, then strobe load on it.
  task automatic load_at_fe(input logic [4*NDIG-1:0] d, input bit z);
    for (int i = 0; i < FLEN && (m_t % FLEN) != FLEN - 1; i++)
      do_cycle(1'b0, 1'b0, '0, z);
    do_cycle(1'b0, 1'b1, d, z);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] e, g;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = {an, seg, pend, frame};
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL outputs @%0t: got an=%b seg=%b pend=%b frame=%b, want an=%b seg=%b pend=%b frame=%b",
                 $time, g[W-1 -: NDIG], g[8:2], g[1], g[0],
                 e[W-1 -: NDIG], e[8:2], e[1], e[0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [4*NDIG-1:0] rd;
    bit rz;
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; load = 1'b0; din = '0; lzb = 1'b0;
    m_t = 0; m_pend = 0;

    // reset with a load held high: load must be ignored
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b1, 16'h1234, 1'b0);

    // commit timing: load at cycle 2, shown in the following frame
    idle(2, 1'b0);
    do_cycle(1'b0, 1'b1, 16'h1234, 1'b0);
    idle(2 * FLEN, 1'b0);

    // leading-zero blanking
    do_cycle(1'b0, 1'b1, 16'h0070, 1'b1);
    idle(2 * FLEN, 1'b1);
    idle(FLEN, 1'b0);
    do_cycle(1'b0, 1'b1, 16'h0000, 1'b1);
    idle(2 * FLEN, 1'b1);

    // load coincident with frame end
    load_at_fe(16'h9999, 1'b0);
    idle(FLEN + 2, 1'b0);

    // double load in one frame
    do_cycle(1'b0, 1'b1, 16'h1111, 1'b0);
    idle(3, 1'b0);
    do_cycle(1'b0, 1'b1, 16'h2222, 1'b0);
    idle(2 * FLEN, 1'b0);

    // invalid codes
    do_cycle(1'b0, 1'b1, 16'hFEDA, 1'b0);
    idle(2 * FLEN, 1'b0);

    // reset mid-frame with pending data
    idle(5, 1'b0);
    do_cycle(1'b0, 1'b1, 16'h5678, 1'b0);
    do_cycle(1'b1, 1'b0, '0, 1'b0);
    idle(2 * FLEN, 1'b0);

    // randomized traffic
    rz = 1'b0;
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < NDIG; k++)
        rd[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) rz = ~rz;
      do_cycle($urandom_range(0, 249) == 0, $urandom_range(0, 9) == 0, rd, rz);
    end

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
